// File: rtl/usb_rx_packet_ctrl.sv
// USB full-speed receive packet controller: validates SYNC/PID, classifies token/data/handshake
// packets and gates payload bytes into the RX FIFO under length and capacity limits.
module usb_rx_packet_ctrl #(
    parameter int         BUF_DEPTH      = 64,
    parameter int         OCC_W          = 7,
    parameter int         MAX_DATA       = 64,
    parameter logic [7:0] SYNC_BYTE      = 8'h80,
    parameter bit         CHECK_PID_COMP = 1'b1,
    localparam int        CNT_W          = $clog2(MAX_DATA + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_edge,
    input  logic             eop,
    input  logic             byte_received,
    input  logic [7:0]       rcv_data,
    input  logic [OCC_W-1:0] buffer_occupancy,
    output logic             rx_transfer_active,
    output logic             rx_data_ready,
    output logic [3:0]       rx_packet,
    output logic [7:0]       rx_packet_data,
    output logic             store_rx_packet_data,
    output logic             flush,
    output logic             rx_error,
    output logic [2:0]       rx_err_code,
    output logic             rx_packet_done,
    output logic [CNT_W-1:0] rx_byte_count
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SYNC     = 3'd1;
    localparam logic [2:0] ST_PID      = 3'd2;
    localparam logic [2:0] ST_TOKEN    = 3'd3;
    localparam logic [2:0] ST_DATA     = 3'd4;
    localparam logic [2:0] ST_WAIT_EOP = 3'd5;
    localparam logic [2:0] ST_ERR      = 3'd6;
    localparam logic [2:0] ST_DONE     = 3'd7;

    localparam logic [2:0] ERR_SYNC = 3'd1;
    localparam logic [2:0] ERR_EOP  = 3'd2;
    localparam logic [2:0] ERR_PID  = 3'd3;
    localparam logic [2:0] ERR_LEN  = 3'd4;
    localparam logic [2:0] ERR_OVF  = 3'd5;

    localparam logic [OCC_W-1:0] FULL_LEVEL = OCC_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_DATA);
    localparam logic [CNT_W-1:0] CNT_MIN    = CNT_W'(2);

    logic [2:0]       state, state_d;
    logic [1:0]       tok_cnt, tok_cnt_d;
    logic             err_eop, err_eop_d;
    logic             active_d, ready_d, store_d, flush_d, error_d, done_d;
    logic [3:0]       packet_d;
    logic [7:0]       data_d;
    logic [2:0]       code_d, err_kind;
    logic [CNT_W-1:0] count_d, count_after;
    logic             err_hit, err_on_eop, take_byte;
    logic             pid_ok, fifo_full, at_max;

    assign pid_ok    = !CHECK_PID_COMP || (rcv_data[7:4] == ~rcv_data[3:0]);
    assign fifo_full = buffer_occupancy >= FULL_LEVEL;
    assign at_max    = rx_byte_count == CNT_MAX;

    always_comb begin
        // NOTE: every signal gets a default here so no path through the case leaves one unassigned (no latches).
        state_d     = state;
        tok_cnt_d   = tok_cnt;
        err_eop_d   = err_eop;
        packet_d    = rx_packet;
        data_d      = rx_packet_data;
        count_d     = rx_byte_count;
        error_d     = rx_error;
        code_d      = rx_err_code;
        ready_d     = 1'b0;
        store_d     = 1'b0;
        flush_d     = 1'b0;
        err_hit     = 1'b0;
        err_kind    = 3'd0;
        err_on_eop  = 1'b0;
        take_byte   = 1'b0;
        count_after = rx_byte_count;

        case (state)
            ST_IDLE: begin
                if (d_edge) begin
                    state_d   = ST_SYNC;
                    error_d   = 1'b0;
                    code_d    = 3'd0;
                    count_d   = '0;
                    tok_cnt_d = 2'd0;
                    err_eop_d = 1'b0;
                end
            end
            ST_SYNC: begin
                if (byte_received) begin
                    if (rcv_data == SYNC_BYTE) state_d = ST_PID;
                    else begin
                        err_hit  = 1'b1;
                        err_kind = ERR_SYNC;
                    end
                end else if (eop) begin
                    err_hit    = 1'b1;
                    err_kind   = ERR_EOP;
                    err_on_eop = 1'b1;
                end
            end
            ST_PID: begin
                if (byte_received) begin
                    if (!pid_ok) begin
                        err_hit  = 1'b1;
                        err_kind = ERR_PID;
                    end else begin
                        case (rcv_data[3:0])
                            4'b0001, 4'b1001, 4'b1101: state_d = ST_TOKEN;
                            4'b0011, 4'b1011: begin
                                state_d = ST_DATA;
                                flush_d = 1'b1;
                            end
                            4'b0010, 4'b1010, 4'b1110: state_d = ST_WAIT_EOP;
                            default: begin
                                err_hit  = 1'b1;
                                err_kind = ERR_PID;
                            end
                        endcase
                        if (!err_hit) begin
                            packet_d = rcv_data[3:0];
                            ready_d  = 1'b1;
                        end
                    end
                end else if (eop) begin
                    err_hit    = 1'b1;
                    err_kind   = ERR_EOP;
                    err_on_eop = 1'b1;
                end
            end
            ST_TOKEN: begin
                if (byte_received) begin
                    data_d    = rcv_data;
                    ready_d   = 1'b1;
                    tok_cnt_d = tok_cnt + 2'd1;
                    if (tok_cnt == 2'd1) state_d = eop ? ST_DONE : ST_WAIT_EOP;
                    else if (eop) begin
                        err_hit    = 1'b1;
                        err_kind   = ERR_EOP;
                        err_on_eop = 1'b1;
                    end
                end else if (eop) begin
                    err_hit    = 1'b1;
                    err_kind   = ERR_EOP;
                    err_on_eop = 1'b1;
                end
            end
            ST_DATA: begin
                // A byte arriving with eop is handled first; the length check then sees the new count.
                take_byte   = byte_received && !fifo_full && !at_max;
                count_after = take_byte ? rx_byte_count + CNT_W'(1) : rx_byte_count;
                if (byte_received && !take_byte) begin
                    err_hit    = 1'b1;
                    err_kind   = ERR_OVF;
                    err_on_eop = eop;
                end else begin
                    if (take_byte) begin
                        data_d  = rcv_data;
                        store_d = 1'b1;
                        ready_d = 1'b1;
                        count_d = count_after;
                    end
                    if (eop) begin
                        if (count_after < CNT_MIN) begin
                            err_hit    = 1'b1;
                            err_kind   = ERR_LEN;
                            err_on_eop = 1'b1;
                        end else state_d = ST_DONE;
                    end
                end
            end
            ST_WAIT_EOP: begin
                if (eop) state_d = ST_DONE;
                else if (byte_received) begin
                    err_hit  = 1'b1;
                    err_kind = ERR_LEN;
                end
            end
            ST_ERR: begin
                if (eop || err_eop) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // The first error of a packet owns the code; the FIFO is flushed on every error entry.
        if (err_hit) begin
            state_d   = ST_ERR;
            flush_d   = 1'b1;
            err_eop_d = err_on_eop;
            if (!rx_error) begin
                error_d = 1'b1;
                code_d  = err_kind;
            end
        end

        active_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d   = state_d == ST_DONE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= ST_IDLE;
            tok_cnt              <= 2'd0;
            err_eop              <= 1'b0;
            rx_transfer_active   <= 1'b0;
            rx_data_ready        <= 1'b0;
            rx_packet            <= 4'd0;
            rx_packet_data       <= 8'd0;
            store_rx_packet_data <= 1'b0;
            flush                <= 1'b0;
            rx_error             <= 1'b0;
            rx_err_code          <= 3'd0;
            rx_packet_done       <= 1'b0;
            rx_byte_count        <= '0;
        end else begin
            state                <= state_d;
            tok_cnt              <= tok_cnt_d;
            err_eop              <= err_eop_d;
            rx_transfer_active   <= active_d;
            rx_data_ready        <= ready_d;
            rx_packet            <= packet_d;
            rx_packet_data       <= data_d;
            store_rx_packet_data <= store_d;
            flush                <= flush_d;
            rx_error             <= error_d;
            rx_err_code          <= code_d;
            rx_packet_done       <= done_d;
            rx_byte_count        <= count_d;
        end
    end

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// Bench for usb_rx_packet_ctrl: three configurations (default, no PID complement check,
// MAX_DATA=8) share one stimulus stream and are compared against a packet-level model.
module tb_usb_rx_packet_ctrl;

    localparam int         ND   = 3;
    localparam logic [7:0] SYNC = 8'h80;
    localparam int         SMAX = 2048;

    logic       clk = 1'b0;
    logic       rst, d_edge, eop, byte_received;
    logic [7:0] rcv_data;
    logic [6:0] buffer_occupancy;

    logic [ND-1:0]      act, rdy, st, fl, err, done;
    logic [ND-1:0][3:0] pkt;
    logic [ND-1:0][7:0] pd;
    logic [ND-1:0][2:0] code;
    logic [6:0]         bc0, bc1;
    logic [3:0]         bc2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    usb_rx_packet_ctrl dut0 (
        .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop), .byte_received(byte_received),
        .rcv_data(rcv_data), .buffer_occupancy(buffer_occupancy),
        .rx_transfer_active(act[0]), .rx_data_ready(rdy[0]), .rx_packet(pkt[0]),
        .rx_packet_data(pd[0]), .store_rx_packet_data(st[0]), .flush(fl[0]),
        .rx_error(err[0]), .rx_err_code(code[0]), .rx_packet_done(done[0]), .rx_byte_count(bc0));

    usb_rx_packet_ctrl #(.CHECK_PID_COMP(1'b0)) dut1 (
        .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop), .byte_received(byte_received),
        .rcv_data(rcv_data), .buffer_occupancy(buffer_occupancy),
        .rx_transfer_active(act[1]), .rx_data_ready(rdy[1]), .rx_packet(pkt[1]),
        .rx_packet_data(pd[1]), .store_rx_packet_data(st[1]), .flush(fl[1]),
        .rx_error(err[1]), .rx_err_code(code[1]), .rx_packet_done(done[1]), .rx_byte_count(bc1));

    usb_rx_packet_ctrl #(.MAX_DATA(8)) dut2 (
        .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop), .byte_received(byte_received),
        .rcv_data(rcv_data), .buffer_occupancy(buffer_occupancy),
        .rx_transfer_active(act[2]), .rx_data_ready(rdy[2]), .rx_packet(pkt[2]),
        .rx_packet_data(pd[2]), .store_rx_packet_data(st[2]), .flush(fl[2]),
        .rx_error(err[2]), .rx_err_code(code[2]), .rx_packet_done(done[2]), .rx_byte_count(bc2));

    bit cfg_comp[ND] = '{1'b1, 1'b0, 1'b1};
    int cfg_maxd[ND] = '{64, 64, 8};

    function automatic logic [6:0] get_bc(input int d);
        case (d)
            0:       return bc0;
            1:       return bc1;
            default: return {3'b000, bc2};
        endcase
    endfunction

    // Pulse monitor: counts one-cycle strobes and records stored bytes in order.
    int         n_rdy[ND]  = '{default: 0};
    int         n_st[ND]   = '{default: 0};
    int         n_fl[ND]   = '{default: 0};
    int         n_done[ND] = '{default: 0};
    logic [7:0] got_st[ND][0:SMAX-1];

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (rdy[d] === 1'b1) n_rdy[d] <= n_rdy[d] + 1;
            if (fl[d] === 1'b1) n_fl[d] <= n_fl[d] + 1;
            if (done[d] === 1'b1) n_done[d] <= n_done[d] + 1;
            if (st[d] === 1'b1) begin
                if (n_st[d] < SMAX) got_st[d][n_st[d]] <= pd[d];
                n_st[d] <= n_st[d] + 1;
            end
        end
    end

    // Packet description: bytes after d_edge (SYNC first), occupancy seen with each byte.
    logic [7:0] pk_b[0:63];
    logic [6:0] pk_occ[0:63];
    int         pk_len;

    int         exp_code[ND], exp_rdy[ND], exp_fl[ND], exp_nst[ND], exp_lat[ND];
    logic [7:0] exp_st[ND][0:63];
    logic [3:0] exp_pkt[ND] = '{default: 4'd0};
    logic [7:0] exp_pd[ND]  = '{default: 8'd0};

    function automatic int pid_kind(input logic [3:0] n);
        case (n)
            4'b0001, 4'b1001, 4'b1101: return 1;
            4'b0011, 4'b1011:          return 2;
            4'b0010, 4'b1010, 4'b1110: return 3;
            default:                   return 0;
        endcase
    endfunction

    // Walks the packet byte list and predicts the packet-level outcome for configuration d.
    task automatic model(input int d);
        int         c, cnt, rem, kind;
        bit         eop_err;
        logic [7:0] pid;
        c = 0; cnt = 0; eop_err = 1'b0;
        exp_rdy[d] = 0; exp_fl[d] = 0;
        if (pk_len == 0) begin c = 2; eop_err = 1'b1; end
        else if (pk_b[0] != SYNC) c = 1;
        else if (pk_len == 1) begin c = 2; eop_err = 1'b1; end
        else begin
            pid  = pk_b[1];
            kind = (cfg_comp[d] && pid[7:4] != ~pid[3:0]) ? 0 : pid_kind(pid[3:0]);
            rem  = pk_len - 2;
            if (kind == 0) c = 3;
            else begin
                exp_pkt[d] = pid[3:0];
                exp_rdy[d]++;
                if (kind == 1) begin
                    for (int k = 0; k < rem && k < 2; k++) begin
                        exp_rdy[d]++;
                        exp_pd[d] = pk_b[2+k];
                    end
                    if (rem < 2) begin c = 2; eop_err = 1'b1; end
                    else if (rem > 2) c = 4;
                end else if (kind == 2) begin
                    exp_fl[d]++;
                    for (int k = 0; k < rem; k++) begin
                        if (pk_occ[2+k] >= 7'd64 || cnt == cfg_maxd[d]) begin c = 5; break; end
                        exp_st[d][cnt] = pk_b[2+k];
                        exp_pd[d] = pk_b[2+k];
                        exp_rdy[d]++;
                        cnt++;
                    end
                    if (c == 0 && cnt < 2) begin c = 4; eop_err = 1'b1; end
                end else if (rem > 0) c = 4;
            end
        end
        if (c != 0) exp_fl[d]++;
        exp_code[d] = c;
        exp_nst[d]  = cnt;
        exp_lat[d]  = eop_err ? 2 : 1;
    endtask

    task automatic drive(input logic de, input logic br, input logic [7:0] data,
                         input logic [6:0] occ, input logic e);
        d_edge = de; byte_received = br; rcv_data = data; buffer_occupancy = occ; eop = e;
        @(negedge clk);
    endtask

    task automatic clear_pkt();
        pk_len = 0;
    endtask

    task automatic push(input logic [7:0] b, input logic [6:0] occ);
        pk_b[pk_len]   = b;
        pk_occ[pk_len] = occ;
        pk_len++;
    endtask

    // Sends the loaded packet (d_edge, bytes with random gaps, eop) and compares every DUT.
    task automatic run_packet(input string name);
        int b_rdy[ND], b_st[ND], b_fl[ND], b_done[ND];
        int mism;
        for (int d = 0; d < ND; d++) begin
            model(d);
            b_rdy[d] = n_rdy[d]; b_st[d] = n_st[d]; b_fl[d] = n_fl[d]; b_done[d] = n_done[d];
        end
        drive(1'b1, 1'b0, 8'h00, 7'd0, 1'b0);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (act[d] !== 1'b1 || err[d] !== 1'b0 || code[d] !== 3'd0 || get_bc(d) !== 7'd0) begin
                errors++;
                $display("FAIL %s dut%0d start: act=%b err=%b code=%0d cnt=%0d want act=1 err=0 code=0 cnt=0",
                         name, d, act[d], err[d], code[d], get_bc(d));
            end
        end
        for (int i = 0; i < pk_len; i++) begin
            repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 8'($urandom), pk_occ[i], 1'b0);
            drive(1'b0, 1'b1, pk_b[i], pk_occ[i], 1'b0);
        end
        repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 8'($urandom), 7'd0, 1'b0);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (act[d] !== 1'b1) begin
                errors++;
                $display("FAIL %s dut%0d active_before_eop: got %b want 1", name, d, act[d]);
            end
        end
        drive(1'b0, 1'b0, 8'h00, 7'd0, 1'b1);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (done[d] !== (exp_lat[d] == 1)) begin
                errors++;
                $display("FAIL %s dut%0d done_cycle1: got %b want %b", name, d, done[d], exp_lat[d] == 1);
            end
        end
        drive(1'b0, 1'b0, 8'h00, 7'd0, 1'b0);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (done[d] !== (exp_lat[d] == 2)) begin
                errors++;
                $display("FAIL %s dut%0d done_cycle2: got %b want %b", name, d, done[d], exp_lat[d] == 2);
            end
        end
        repeat (3) drive(1'b0, 1'b0, 8'h00, 7'd0, 1'b0);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (n_done[d] - b_done[d] != 1 || act[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s dut%0d done_count/idle: done=%0d act=%b want done=1 act=0",
                         name, d, n_done[d] - b_done[d], act[d]);
            end
            checks++;
            if (err[d] !== (exp_code[d] != 0) || code[d] !== 3'(exp_code[d])) begin
                errors++;
                $display("FAIL %s dut%0d error: err=%b code=%0d want err=%b code=%0d",
                         name, d, err[d], code[d], exp_code[d] != 0, exp_code[d]);
            end
            checks++;
            if (n_rdy[d] - b_rdy[d] != exp_rdy[d]) begin
                errors++;
                $display("FAIL %s dut%0d ready_pulses: got %0d want %0d", name, d, n_rdy[d] - b_rdy[d], exp_rdy[d]);
            end
            checks++;
            if (n_fl[d] - b_fl[d] != exp_fl[d]) begin
                errors++;
                $display("FAIL %s dut%0d flush_pulses: got %0d want %0d", name, d, n_fl[d] - b_fl[d], exp_fl[d]);
            end
            mism = 0;
            for (int k = 0; k < exp_nst[d] && k < n_st[d] - b_st[d] && b_st[d] + k < SMAX; k++)
                if (got_st[d][b_st[d]+k] !== exp_st[d][k]) mism++;
            checks++;
            if (n_st[d] - b_st[d] != exp_nst[d] || mism != 0) begin
                errors++;
                $display("FAIL %s dut%0d stores: got %0d (%0d wrong bytes) want %0d",
                         name, d, n_st[d] - b_st[d], mism, exp_nst[d]);
            end
            checks++;
            if (get_bc(d) !== 7'(exp_nst[d])) begin
                errors++;
                $display("FAIL %s dut%0d byte_count: got %0d want %0d", name, d, get_bc(d), exp_nst[d]);
            end
            checks++;
            if (pkt[d] !== exp_pkt[d] || pd[d] !== exp_pd[d]) begin
                errors++;
                $display("FAIL %s dut%0d pid/data: got %h/%h want %h/%h", name, d, pkt[d], pd[d], exp_pkt[d], exp_pd[d]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        d_edge = 1'b0; eop = 1'b0; byte_received = 1'b0; rcv_data = 8'h00; buffer_occupancy = 7'd0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if ({act[d], rdy[d], st[d], fl[d], err[d], done[d], pkt[d], pd[d], code[d], get_bc(d)} !== '0) begin
                errors++;
                $display("FAIL reset dut%0d outputs: got nonzero, want all 0", d);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_out_token();
        clear_pkt();
        push(SYNC, 7'd0); push(8'hE1, 7'd0); push(8'h12, 7'd0); push(8'h34, 7'd0);
        run_packet("out_token");
        checks++;
        if (pkt[0] !== 4'b0001 || pd[0] !== 8'h34 || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL out_token fixed: pid=%h data=%h err=%b want 1/34/0", pkt[0], pd[0], err[0]);
        end
    endtask

    task automatic test_data0();
        clear_pkt();
        push(SYNC, 7'd0); push(8'hC3, 7'd0);
        for (int i = 0; i < 6; i++) push(8'($urandom), 7'd0);
        run_packet("data0_6");
        checks++;
        if (bc0 !== 7'd6) begin
            errors++;
            $display("FAIL data0_6 fixed_count: got %0d want 6", bc0);
        end
    endtask

    task automatic test_bad_pid();
        clear_pkt();
        push(SYNC, 7'd0); push(8'hF1, 7'd0); push(8'h55, 7'd0); push(8'h66, 7'd0);
        run_packet("bad_pid");
        checks++;
        if (code[0] !== 3'd3 || code[1] !== 3'd0 || pkt[1] !== 4'b0001) begin
            errors++;
            $display("FAIL bad_pid fixed: code0=%0d code1=%0d pid1=%h want 3/0/1", code[0], code[1], pkt[1]);
        end
    endtask

    task automatic test_overflow();
        clear_pkt();
        push(SYNC, 7'd0); push(8'h4B, 7'd0);
        push(8'hA1, 7'd10); push(8'hA2, 7'd20); push(8'hA3, 7'd64); push(8'hA4, 7'd0);
        run_packet("overflow");
        repeat (5) drive(1'b0, 1'b0, 8'h00, 7'd0, 1'b0);
        checks++;
        if (err[0] !== 1'b1 || code[0] !== 3'd5 || bc0 !== 7'd2) begin
            errors++;
            $display("FAIL overflow held_in_idle: err=%b code=%0d cnt=%0d want 1/5/2", err[0], code[0], bc0);
        end
    endtask

    task automatic test_max_data();
        clear_pkt();
        push(SYNC, 7'd0); push(8'hC3, 7'd0);
        for (int i = 0; i < 9; i++) push(8'($urandom), 7'd0);
        run_packet("max_data");
        checks++;
        if (bc2 !== 4'd8 || code[2] !== 3'd5 || bc0 !== 7'd9) begin
            errors++;
            $display("FAIL max_data fixed: cnt8=%0d code8=%0d cnt64=%0d want 8/5/9", bc2, code[2], bc0);
        end
        clear_pkt();
        push(SYNC, 7'd0); push(8'hD2, 7'd0); push(8'h77, 7'd0);
        run_packet("ack_extra");
        clear_pkt();
        run_packet("eop_in_sync");
    endtask

    task automatic test_reset_mid_data();
        drive(1'b1, 1'b0, 8'h00, 7'd0, 1'b0);
        drive(1'b0, 1'b1, SYNC, 7'd0, 1'b0);
        drive(1'b0, 1'b1, 8'hC3, 7'd0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'($urandom), 7'd0, 1'b0);
        checks++;
        if (bc0 !== 7'd3 || act[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_data before_reset: cnt=%0d act=%b want 3/1", bc0, act[0]);
        end
        rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if ({act[d], rdy[d], st[d], fl[d], err[d], done[d], pkt[d], pd[d], code[d], get_bc(d)} !== '0) begin
                errors++;
                $display("FAIL mid_data_reset dut%0d outputs: got nonzero, want all 0", d);
            end
            exp_pkt[d] = 4'd0;
            exp_pd[d]  = 8'd0;
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 7'd0, 1'b0);
        clear_pkt();
        push(8'h7F, 7'd0); push(8'hE1, 7'd0); push(8'h12, 7'd0);
        run_packet("bad_sync");
    endtask

    task automatic test_random();
        logic [3:0] toks[3] = '{4'b0001, 4'b1001, 4'b1101};
        logic [3:0] dats[2] = '{4'b0011, 4'b1011};
        logic [3:0] hsks[3] = '{4'b0010, 4'b1010, 4'b1110};
        logic [3:0] nib;
        logic [7:0] b;
        int         kind, rem;
        for (int n = 0; n < 40; n++) begin
            clear_pkt();
            kind = $urandom_range(0, 7);
            case (kind)
                0, 1: begin
                    nib = toks[$urandom_range(0, 2)];
                    push(SYNC, 7'd0); push({~nib, nib}, 7'd0);
                    rem = (kind == 0) ? 2 : $urandom_range(0, 3);
                end
                2, 3, 7: begin
                    nib = dats[$urandom_range(0, 1)];
                    push(SYNC, 7'd0); push({~nib, nib}, 7'd0);
                    rem = (kind == 7) ? $urandom_range(8, 12) : $urandom_range(0, 10);
                end
                4: begin
                    nib = hsks[$urandom_range(0, 2)];
                    push(SYNC, 7'd0); push({~nib, nib}, 7'd0);
                    rem = $urandom_range(0, 1);
                end
                5: begin
                    push(SYNC, 7'd0); push(8'($urandom), 7'd0);
                    rem = $urandom_range(0, 3);
                end
                default: begin
                    b = 8'($urandom);
                    if (b == SYNC) b = 8'h81;
                    if ($urandom_range(0, 3) != 0) push(b, 7'd0);
                    rem = $urandom_range(0, 2);
                end
            endcase
            for (int k = 0; k < rem; k++)
                push(8'($urandom), ($urandom_range(0, 15) == 0) ? 7'($urandom_range(64, 127))
                                                                : 7'($urandom_range(0, 63)));
            run_packet("random");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_out_token();
        test_data0();
        test_bad_pid();
        test_overflow();
        test_max_data();
        test_reset_mid_data();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
